velocity_update_broadcast_arbiter: RTL and testbench

- Sequences one motion-update pass for the velocity caches.
- Owns the cache control signals: motion_update_enable, plus the broadcast bus (data, dst cell, valid).
- Shares that single broadcast bus between NUM_REQ motion-update units using round-robin arbitration.
- Holds enable high for the whole pass, drops it only after every requester has finished, then waits for the caches to write their particle counts and swap buffers before pulsing done.

---
 rtl/md_motion_pkg.sv | 33 +++
 rtl/rr_arbiter.sv | 38 +++
 rtl/velocity_update_broadcast_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_velocity_update_broadcast_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_motion_pkg.sv
// Shared types for the motion-update broadcast path: payload/cell widths, packed words, pass FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package md_motion_pkg;

    localparam int MD_DATA_WIDTH    = 32;
    localparam int MD_CELL_ID_WIDTH = 4;
    localparam int MD_VEL_W         = 3 * MD_DATA_WIDTH;
    localparam int MD_CELL_W        = 3 * MD_CELL_ID_WIDTH;

    // Destination cell, x in the low bits.
    typedef struct packed {
        logic [MD_CELL_ID_WIDTH-1:0] z;
        logic [MD_CELL_ID_WIDTH-1:0] y;
        logic [MD_CELL_ID_WIDTH-1:0] x;
    } cell_id_t;

    // Velocity word, vx in the low bits.
    typedef struct packed {
        logic [MD_DATA_WIDTH-1:0] vz;
        logic [MD_DATA_WIDTH-1:0] vy;
        logic [MD_DATA_WIDTH-1:0] vx;
    } vel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_BROADCAST,
        ST_SETTLE,
        ST_DONE
    } mu_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first set request at or above ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; gnt_o is zero when no request is set.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    int   cand;
    logic found;

    // Walk offsets from the pointer; the first requester hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && (j == cand) && req_i[j]) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/velocity_update_broadcast_arbiter.sv
// Sequences one motion-update pass and round-robins NUM_REQ requesters onto one broadcast bus.
// Latency: one cycle from transfer (req_valid & req_ready) to out_data_valid; all outputs but req_ready registered.
// Backpressure: at most one grant per cycle; req_ready only in BROADCAST, no internal buffering.
module velocity_update_broadcast_arbiter
    import md_motion_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = MD_DATA_WIDTH,
    parameter int CELL_ID_WIDTH = MD_CELL_ID_WIDTH,
    parameter int SETTLE_CYCLES = 3,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0]      req_data,
    input  logic [NUM_REQ*3*CELL_ID_WIDTH-1:0]   req_dst_cell,
    input  logic [NUM_REQ-1:0]                   req_last,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic                                 motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]              out_data,
    output logic [3*CELL_ID_WIDTH-1:0]           out_data_dst_cell,
    output logic                                 out_data_valid,
    output logic                                 busy,
    output logic                                 done,
    output logic [CNT_WIDTH-1:0]                 bcast_count
);

    localparam int PAY_W = 3 * DATA_WIDTH;
    localparam int DST_W = 3 * CELL_ID_WIDTH;
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    mu_state_e            state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [NUM_REQ-1:0]   fin_q, fin_d;
    logic [SET_W-1:0]     settle_q, settle_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 enable_q, enable_d;
    logic                 oval_q, oval_d;
    logic [PAY_W-1:0]     odata_q, odata_d;
    logic [DST_W-1:0]     odst_q, odst_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic                 xfer;
    logic [PAY_W-1:0]     sel_data;
    logic [DST_W-1:0]     sel_dst;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Grants are only offered while broadcasting; a grant implies the requester is valid.
    assign req_ready = (state_q == ST_BROADCAST) ? gnt : '0;
    assign xfer      = |req_ready;

    // Pick the granted requester's payload and destination slice.
    always_comb begin
        sel_data = '0;
        sel_dst  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_data = req_data[i*PAY_W +: PAY_W];
                sel_dst  = req_dst_cell[i*DST_W +: DST_W];
            end
        end
    end

    // Pass sequencing, finished tracking, pointer and counters; outputs follow the next state.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        fin_d    = fin_q;
        settle_d = settle_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ARM;
                    fin_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_ARM: begin
                state_d = ST_BROADCAST;
            end
            ST_BROADCAST: begin
                // A requester still presenting its final word is not finished yet.
                fin_d = fin_q | (req_last & ~req_valid);
                if (xfer) begin
                    if (gnt_idx == IDX_W'(NUM_REQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = gnt_idx + 1'b1;
                    end
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (&fin_d) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                // Gives the caches time to write their counts and swap buffers.
                if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        enable_d = (state_d == ST_ARM) || (state_d == ST_BROADCAST);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_d == ST_DONE);
        oval_d   = xfer;
        odata_d  = xfer ? sel_data : '0;
        odst_d   = xfer ? sel_dst  : '0;
    end

    // State register; reset aborts any pass in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            fin_q    <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            oval_q   <= 1'b0;
            odata_q  <= '0;
            odst_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            fin_q    <= fin_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
            oval_q   <= oval_d;
            odata_q  <= odata_d;
            odst_q   <= odst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign motion_update_enable = enable_q;
    assign out_data             = odata_q;
    assign out_data_dst_cell    = odst_q;
    assign out_data_valid       = oval_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign bcast_count          = cnt_q;

endmodule

// File: tb/tb_velocity_update_broadcast_arbiter.sv
// Bench for velocity_update_broadcast_arbiter: directed pass table, reset-abort sequence, random passes.
// Latency: n/a.
// Backpressure: requesters hold their head word until granted.
module tb_velocity_update_broadcast_arbiter;
    import md_motion_pkg::*;

    localparam int N  = 4;
    localparam int PW = MD_VEL_W;
    localparam int CW = MD_CELL_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N*PW-1:0]   req_data;
    logic [N*CW-1:0]   req_dst_cell;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              motion_update_enable;
    logic [PW-1:0]     out_data;
    logic [CW-1:0]     out_data_dst_cell;
    logic              out_data_valid;
    logic              busy;
    logic              done;
    logic [15:0]       bcast_count;

    velocity_update_broadcast_arbiter dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .req_valid            (req_valid),
        .req_data             (req_data),
        .req_dst_cell         (req_dst_cell),
        .req_last             (req_last),
        .req_ready            (req_ready),
        .motion_update_enable (motion_update_enable),
        .out_data             (out_data),
        .out_data_dst_cell    (out_data_dst_cell),
        .out_data_valid       (out_data_valid),
        .busy                 (busy),
        .done                 (done),
        .bcast_count          (bcast_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] nw;        // words per requester
        logic            smid;      // stray start during BROADCAST
        logic            lastearly; // last may rise with the final word still valid
        logic [7:0]      exp_cnt;
        logic [7:0]      exp_en;    // cycles with enable high
        logic [7:0]      exp_done;  // cycle of done, start cycle = 1
        logic [31:0]     exp_ord;   // nibble k = k-th grant, F = unchecked
    } vec_t;

    int       n_vec = 0;
    int       n_err = 0;
    int       mptr = 0;
    bit       gaps_q = 1'b0;
    bit       lastearly_q = 1'b0;
    vel_t     qd [N][$];
    cell_id_t qc [N][$];
    int       grants [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0][3:0] mk_nw(input int a, input int b, input int c, input int d);
        logic [3:0][3:0] r;
        r[0] = 4'(a);
        r[1] = 4'(b);
        r[2] = 4'(c);
        r[3] = 4'(d);
        return r;
    endfunction

    function automatic vec_t mk_vec(input logic [3:0][3:0] nw, input bit smid, input bit le,
                                    input int c, input int e, input int d, input logic [31:0] ord);
        vec_t v;
        v.nw        = nw;
        v.smid      = smid;
        v.lastearly = le;
        v.exp_cnt   = 8'(c);
        v.exp_en    = 8'(e);
        v.exp_done  = 8'(d);
        v.exp_ord   = ord;
        return v;
    endfunction

    // Requesters present their queue head; last is high once the queue is empty.
    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (qd[i].size() == 0) begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b1;
                req_data[i*PW +: PW]     = '0;
                req_dst_cell[i*CW +: CW] = '0;
            end else begin
                req_last[i]  = (qd[i].size() == 1) && lastearly_q && ($urandom_range(0, 1) == 1);
                req_valid[i] = req_last[i] || !gaps_q || ($urandom_range(0, 3) != 0);
                req_data[i*PW +: PW]     = qd[i][0];
                req_dst_cell[i*CW +: CW] = qc[i][0];
            end
        end
    endtask

    function automatic int exp_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(mptr + k) % N]) return (mptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) begin
            if (qd[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic run_pass(input logic [3:0][3:0] nw, input bit start_mid,
                            output int cnt_o, output int en_o, output int done_o);
        int       cyc, pend, g, exp_cnt, total, exit_cyc;
        bit       exit_seen, fin;
        vel_t     v, pd;
        cell_id_t c, pc;
        total = 0;
        grants.delete();
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < int'(nw[i]); k++) begin
                v.vx = $urandom; v.vy = $urandom; v.vz = $urandom;
                c = cell_id_t'($urandom_range(0, 4095));
                qd[i].push_back(v);
                qc[i].push_back(c);
            end
            total += int'(nw[i]);
        end
        en_o = 0; done_o = 0; cnt_o = 0; pend = -1; exp_cnt = 0;
        exit_seen = 1'b0; fin = 1'b0; exit_cyc = 0; pd = '0; pc = '0;

        drive_inputs();
        start = 1'b1;
        cyc = 1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 2;
        chk("arm_enable", 128'(motion_update_enable), 128'(1));
        chk("arm_busy", 128'(busy), 128'(1));
        chk("arm_out_valid", 128'(out_data_valid), 128'(0));
        chk("arm_count_cleared", 128'(bcast_count), 128'(0));
        if (motion_update_enable) en_o++;
        drive_inputs(); #1;
        chk("arm_ready", 128'(req_ready), 128'(0));

        for (int t = 0; t < 300 && !fin; t++) begin
            @(posedge clk); #1;
            cyc++;
            if (motion_update_enable) en_o++;
            if (pend >= 0) begin
                chk("bus_valid", 128'(out_data_valid), 128'(1));
                chk("bus_data", 128'(out_data), 128'(pd));
                chk("bus_dst", 128'(out_data_dst_cell), 128'(pc));
                exp_cnt++;
                chk("bus_count", 128'(bcast_count), 128'(exp_cnt));
                void'(qd[pend].pop_front());
                void'(qc[pend].pop_front());
            end else begin
                chk("bus_idle_valid", 128'(out_data_valid), 128'(0));
                chk("bus_idle_data", 128'(out_data), 128'(0));
            end
            if (exit_seen) begin
                chk("settle_enable_low", 128'(motion_update_enable), 128'(0));
                chk("settle_busy", 128'(busy), 128'(1));
                fin = 1'b1;
            end else begin
                chk("bcast_enable", 128'(motion_update_enable), 128'(1));
                start = start_mid && (cyc == 3);
                drive_inputs(); #1;
                g = exp_grant();
                chk("grant", 128'(req_ready), (g < 0) ? 128'(0) : 128'(1) << g);
                if (g >= 0) begin
                    pend = g;
                    pd   = qd[g][0];
                    pc   = qc[g][0];
                    mptr = (g + 1) % N;
                    grants.push_back(g);
                end else begin
                    pend = -1;
                    if (all_empty()) begin
                        exit_seen = 1'b1;
                        exit_cyc  = cyc;
                    end
                end
            end
        end
        start = 1'b0;
        chk("exit_reached", 128'(fin), 128'(1));

        for (int t = 0; t < 12 && done_o == 0; t++) begin
            @(posedge clk); #1;
            cyc++;
            if (motion_update_enable) en_o++;
            if (done) done_o = cyc;
        end
        chk("done_after_settle", 128'(done_o), 128'(exit_cyc + 4));
        chk("enable_cycles", 128'(en_o), 128'(exit_cyc - 1));
        cnt_o = int'(bcast_count);
        chk("count_total", 128'(bcast_count), 128'(total));
        @(posedge clk); #1;
        chk("done_single", 128'(done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_enable", 128'(motion_update_enable), 128'(0));
        chk("count_hold", 128'(bcast_count), 128'(total));
        @(posedge clk); #1;
        chk("start_not_queued", 128'(busy), 128'(0));
    endtask

    initial begin
        vec_t     tbl [6];
        int       cnt, en, dn;
        bit       saw;
        vel_t     v;
        cell_id_t c;
        logic [3:0] nib;
        logic [3:0][3:0] nwr;

        tbl[0] = mk_vec(mk_nw(0, 0, 0, 0), 1'b0, 1'b0, 0, 2, 7,  32'hFFFF_FFFF);
        tbl[1] = mk_vec(mk_nw(2, 2, 2, 2), 1'b1, 1'b0, 8, 10, 15, 32'h3210_3210);
        tbl[2] = mk_vec(mk_nw(0, 0, 3, 0), 1'b0, 1'b0, 3, 5, 10, 32'hFFFF_F222);
        tbl[3] = mk_vec(mk_nw(1, 0, 0, 2), 1'b0, 1'b0, 3, 5, 10, 32'hFFFF_F303);
        tbl[4] = mk_vec(mk_nw(1, 2, 0, 5), 1'b1, 1'b1, 8, 10, 15, 32'h3333_1310);
        tbl[5] = mk_vec(mk_nw(0, 1, 0, 0), 1'b0, 1'b1, 1, 3, 8,  32'hFFFF_FFF1);

        req_valid = '0; req_last = '0; req_data = '0; req_dst_cell = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_enable", 128'(motion_update_enable), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_valid", 128'(out_data_valid), 128'(0));
        chk("rst_data", 128'(out_data), 128'(0));
        chk("rst_count", 128'(bcast_count), 128'(0));
        chk("rst_ready", 128'(req_ready), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 6; r++) begin
            gaps_q      = 1'b0;
            lastearly_q = tbl[r].lastearly;
            run_pass(tbl[r].nw, tbl[r].smid, cnt, en, dn);
            chk("tbl_count", 128'(cnt), 128'(tbl[r].exp_cnt));
            chk("tbl_enable_cycles", 128'(en), 128'(tbl[r].exp_en));
            chk("tbl_done_cycle", 128'(dn), 128'(tbl[r].exp_done));
            for (int k = 0; k < 8; k++) begin
                nib = tbl[r].exp_ord[k*4 +: 4];
                if (nib != 4'hF) begin
                    chk("tbl_grant_order", (k < grants.size()) ? 128'(grants[k]) : 128'hFF, 128'(nib));
                end
            end
        end

        // Reset landing in SETTLE aborts the pass without done.
        gaps_q = 1'b0; lastearly_q = 1'b0;
        v.vx = $urandom; v.vy = $urandom; v.vz = $urandom;
        c = cell_id_t'($urandom_range(0, 4095));
        qd[0].push_back(v); qc[0].push_back(c);
        drive_inputs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rs_grant", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        chk("rs_word", 128'(out_data), 128'(v));
        void'(qd[0].pop_front()); void'(qc[0].pop_front());
        drive_inputs();
        @(posedge clk); #1;
        chk("rs_in_settle", 128'(motion_update_enable), 128'(0));
        chk("rs_settle_busy", 128'(busy), 128'(1));
        chk("rs_settle_count", 128'(bcast_count), 128'(1));
        rst = 1'b1;
        #1;
        chk("rs_async_busy", 128'(busy), 128'(0));
        chk("rs_async_enable", 128'(motion_update_enable), 128'(0));
        chk("rs_async_count", 128'(bcast_count), 128'(0));
        chk("rs_async_done", 128'(done), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mptr = 0;
        saw = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) saw = 1'b1;
        end
        chk("rs_no_done", 128'(saw), 128'(0));
        run_pass(mk_nw(1, 1, 0, 0), 1'b0, cnt, en, dn);
        chk("rs_clean_count", 128'(cnt), 128'(2));
        chk("rs_clean_done", 128'(dn), 128'(9));
        chk("rs_ptr_from_zero", (grants.size() > 0) ? 128'(grants[0]) : 128'hFF, 128'(0));

        // Random passes with valid gaps and early last.
        for (int p = 0; p < 8; p++) begin
            gaps_q      = 1'b1;
            lastearly_q = 1'b1;
            for (int i = 0; i < N; i++) nwr[i] = 4'($urandom_range(0, 4));
            run_pass(nwr, 1'($urandom_range(0, 1)), cnt, en, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
